// File: rtl/fb_fetch_arbiter.sv
// Framebuffer RAM arbiter: per-line scanout prefetch into a double-banked line buffer, host gets idle slots.
// Optional macro FB_FETCH_ARB_HOST_READ_EN adds host reads; without it every granted host access is a write.
module fb_fetch_arbiter #(
  parameter int CORDW          = 16,
  parameter int V_RES          = 480,
  parameter int WORDS_PER_LINE = 40,
  parameter int ADDRW          = 15,
  parameter int DATAW          = 16
) (
  input  logic                    clk_pix,
  input  logic                    rst_pix_n,
  input  logic                    frame,
  input  logic                    line,
  input  logic signed [CORDW-1:0] sy,
  input  logic                    host_req,
  input  logic                    host_we,
  input  logic [ADDRW-1:0]        host_addr,
  input  logic [DATAW-1:0]        host_wdata,
  output logic                    host_gnt,
  output logic                    host_rvalid,
  output logic [DATAW-1:0]        host_rdata,
  output logic [ADDRW-1:0]        mem_addr,
  output logic                    mem_we,
  output logic [DATAW-1:0]        mem_wdata,
  input  logic [DATAW-1:0]        mem_rdata,
  output logic                    lb_we,
  output logic                    lb_bank,
  output logic [7:0]              lb_addr,
  output logic [DATAW-1:0]        lb_wdata,
  output logic                    disp_bank,
  output logic                    fetch_busy,
  output logic                    fetch_overrun
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FETCH = 1'b1;

  localparam int IDXW = 10;
  localparam logic signed [CORDW-1:0] SY_FIRST  = CORDW'(-1);
  localparam logic signed [CORDW-1:0] SY_LAST   = CORDW'(V_RES - 2);
  localparam logic [IDXW-1:0]         LAST_IDX  = IDXW'(WORDS_PER_LINE - 1);
  localparam logic [ADDRW-1:0]        LINE_STEP = ADDRW'(WORDS_PER_LINE);

  logic [0:0]       state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [ADDRW-1:0] base_q, base_d;
  logic [ADDRW-1:0] fetch_base_q, fetch_base_d;
  logic             lb_bank_q, lb_bank_d;
  logic             lb_we_q, lb_we_d;
  logic [7:0]       lb_addr_q, lb_addr_d;
  logic             overrun_q, overrun_d;
  logic             trig;

  // Line y fetches line y+1, so line -1 loads line 0 and the last active line needs no fetch.
  assign trig = line && (sy >= SY_FIRST) && (sy <= SY_LAST);

  // NOTE: every always_comb target gets a default first; a missed branch would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    fetch_base_d = fetch_base_q;
    lb_bank_d    = lb_bank_q;
    overrun_d    = overrun_q;
    // NOTE: blocking assignments here are deliberate; base_d is refined in place before the trigger uses it.
    base_d       = frame ? '0 : base_q;

    if (trig) begin
      state_d      = FETCH;
      idx_d        = '0;
      lb_bank_d    = ~lb_bank_q;
      fetch_base_d = base_d;
      base_d       = base_d + LINE_STEP;
      if (state_q == FETCH) overrun_d = 1'b1;
    end else if (state_q == FETCH) begin
      idx_d = idx_q + 1'b1;
      if (idx_q == LAST_IDX) state_d = IDLE;
    end

    // A read issued on the cycle a restart hits belongs to the abandoned line and the old bank.
    lb_we_d   = (state_q == FETCH) && !trig;
    lb_addr_d = lb_we_d ? idx_q[7:0] : lb_addr_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      base_q       <= '0;
      fetch_base_q <= '0;
      lb_bank_q    <= 1'b0;
      lb_we_q      <= 1'b0;
      lb_addr_q    <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      base_q       <= base_d;
      fetch_base_q <= fetch_base_d;
      lb_bank_q    <= lb_bank_d;
      lb_we_q      <= lb_we_d;
      lb_addr_q    <= lb_addr_d;
      overrun_q    <= overrun_d;
    end
  end

  assign fetch_busy    = (state_q == FETCH);
  assign fetch_overrun = overrun_q;
  assign host_gnt      = !fetch_busy && host_req && !trig;

  assign mem_addr  = fetch_busy ? (fetch_base_q + ADDRW'(idx_q))
                   : (host_gnt ? host_addr : '0);
  assign mem_wdata = host_gnt ? host_wdata : '0;

  assign lb_we     = lb_we_q;
  assign lb_bank   = lb_bank_q;
  assign disp_bank = ~lb_bank_q;
  assign lb_addr   = lb_addr_q;
  assign lb_wdata  = lb_we_q ? mem_rdata : '0;

`ifdef FB_FETCH_ARB_HOST_READ_EN
  logic             rvalid_q;
  logic [DATAW-1:0] rdata_q;

  assign mem_we = host_gnt && host_we;

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= host_gnt && !host_we;
      if (rvalid_q) rdata_q <= mem_rdata;
    end
  end

  // RAM data is live on the rvalid cycle; the register only holds it afterwards.
  assign host_rvalid = rvalid_q;
  assign host_rdata  = rvalid_q ? mem_rdata : rdata_q;
`else
  logic unused_host_we;

  assign unused_host_we = host_we;
  assign mem_we         = host_gnt;
  assign host_rvalid    = 1'b0;
  assign host_rdata     = '0;
`endif

endmodule

// File: tb/tb_fb_fetch_arbiter.sv
// Directed bench for fb_fetch_arbiter with a synchronous-read RAM model preloaded with a known pattern.
module tb_fb_fetch_arbiter;

  localparam int WPL = 40;
`ifdef FB_FETCH_ARB_HOST_READ_EN
  localparam bit RD_EN = 1'b1;
`else
  localparam bit RD_EN = 1'b0;
`endif

  logic               clk_pix = 1'b0;
  logic               rst_pix_n;
  logic               frame, line;
  logic signed [15:0] sy;
  logic               host_req, host_we;
  logic [14:0]        host_addr;
  logic [15:0]        host_wdata;
  logic               host_gnt, host_rvalid;
  logic [15:0]        host_rdata;
  logic [14:0]        mem_addr;
  logic               mem_we;
  logic [15:0]        mem_wdata, mem_rdata;
  logic               lb_we, lb_bank, disp_bank, fetch_busy, fetch_overrun;
  logic [7:0]         lb_addr;
  logic [15:0]        lb_wdata;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] ram [0:32767];

  fb_fetch_arbiter dut (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .frame(frame), .line(line), .sy(sy),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .lb_we(lb_we), .lb_bank(lb_bank), .lb_addr(lb_addr), .lb_wdata(lb_wdata),
    .disp_bank(disp_bank), .fetch_busy(fetch_busy), .fetch_overrun(fetch_overrun)
  );

  always #5 clk_pix = ~clk_pix;

  always @(posedge clk_pix) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  function automatic logic [15:0] pat(input int a);
    return 16'(a * 7) ^ 16'hA5A5;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_host_gnt",      host_gnt,      0);
    check("rst_host_rvalid",   host_rvalid,   0);
    check("rst_host_rdata",    host_rdata,    0);
    check("rst_mem_we",        mem_we,        0);
    check("rst_mem_addr",      mem_addr,      0);
    check("rst_mem_wdata",     mem_wdata,     0);
    check("rst_lb_we",         lb_we,         0);
    check("rst_lb_bank",       lb_bank,       0);
    check("rst_disp_bank",     disp_bank,     1);
    check("rst_lb_addr",       lb_addr,       0);
    check("rst_lb_wdata",      lb_wdata,      0);
    check("rst_fetch_busy",    fetch_busy,    0);
    check("rst_fetch_overrun", fetch_overrun, 0);
  endtask

  // Called in the trigger cycle T; returns in cycle T+WPL+1 (final lb write).
  task automatic run_fetch(input int base, input logic bank, input logic gnt_last);
    for (int k = 0; k <= WPL; k++) begin
      tick();
      line  = 1'b0;
      frame = 1'b0;
      #1;
      if (k < WPL) begin
        check($sformatf("busy_b%0d_k%0d", base, k), fetch_busy, 1);
        check($sformatf("addr_b%0d_k%0d", base, k), mem_addr, base + k);
        check($sformatf("mwe_b%0d_k%0d", base, k), mem_we, 0);
        check($sformatf("gnt_b%0d_k%0d", base, k), host_gnt, 0);
        check($sformatf("bank_b%0d_k%0d", base, k), lb_bank, bank);
        check($sformatf("dbank_b%0d_k%0d", base, k), disp_bank, !bank);
      end else begin
        check($sformatf("busy_end_b%0d", base), fetch_busy, 0);
        check($sformatf("gnt_end_b%0d", base), host_gnt, gnt_last);
      end
      if (k > 0) begin
        check($sformatf("lbwe_b%0d_k%0d", base, k), lb_we, 1);
        check($sformatf("lbaddr_b%0d_k%0d", base, k), lb_addr, k - 1);
        check($sformatf("lbdata_b%0d_k%0d", base, k), lb_wdata, pat(base + k - 1));
      end
    end
  endtask

  initial begin
    bit saw_we;
    for (int i = 0; i < 32768; i++) ram[i] = pat(i);
    rst_pix_n = 1'b0; frame = 1'b0; line = 1'b0; sy = 16'sd0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    #1;
    check_reset_outputs();
    tick(); tick();
    #2 rst_pix_n = 1'b1;

    // Line 0 fetch with frame alignment.
    tick();
    frame = 1'b1; line = 1'b1; sy = -16'sd1;
    #1;
    check("trig_cycle_busy", fetch_busy, 0);
    run_fetch(0, 1'b1, 1'b0);
    tick();
    check("idle_lb_we", lb_we, 0);

    // Base advance, then out-of-range lines must not fetch.
    line = 1'b1; sy = 16'sd0;
    run_fetch(40, 1'b0, 1'b0);
    tick();
    line = 1'b1; sy = 16'sd1;
    run_fetch(80, 1'b1, 1'b0);
    tick();
    line = 1'b1; sy = 16'sd479;
    tick();
    line = 1'b0;
    #1;
    check("sy479_no_fetch", fetch_busy, 0);
    check("sy479_bank", lb_bank, 1);
    line = 1'b1; sy = -16'sd2;
    tick();
    line = 1'b0;
    #1;
    check("sym2_no_fetch", fetch_busy, 0);
    check("sym2_bank", lb_bank, 1);

    // Collision: host write to 100 waits out the whole fetch.
    tick();
    host_req = 1'b1; host_we = 1'b1; host_addr = 15'd100; host_wdata = 16'hBEEF;
    line = 1'b1; sy = 16'sd2;
    #1;
    check("coll_gnt_T", host_gnt, 0);
    run_fetch(120, 1'b0, 1'b1);
    check("coll_mem_addr", mem_addr, 100);
    check("coll_mem_we", mem_we, 1);
    check("coll_mem_wdata", mem_wdata, 16'hBEEF);
    tick();
    host_req = 1'b0;
    #1;
    check("coll_single_gnt", host_gnt, 0);

    // Back-to-back host writes.
    host_req = 1'b1; host_addr = 15'd1000; host_wdata = 16'h1111;
    #1;
    check("tput_gnt0", host_gnt, 1);
    check("tput_addr0", mem_addr, 1000);
    check("tput_wdata0", mem_wdata, 16'h1111);
    tick();
    host_addr = 15'd1001; host_wdata = 16'h2222;
    #1;
    check("tput_gnt1", host_gnt, 1);
    check("tput_addr1", mem_addr, 1001);
    check("tput_we1", mem_we, 1);

    // Host read of address 100.
    tick();
    host_we = 1'b0; host_addr = 15'd100; host_wdata = 16'h5A5A;
    #1;
    check("rd_gnt", host_gnt, 1);
    check("rd_mem_addr", mem_addr, 100);
    check("rd_mem_we", mem_we, !RD_EN);
    check("rd_rvalid_C", host_rvalid, 0);
    tick();
    host_req = 1'b0;
    #1;
    check("rd_rvalid_C1", host_rvalid, RD_EN);
    check("rd_rdata_C1", host_rdata, RD_EN ? 16'hBEEF : 16'h0000);
    tick();
    check("rd_rvalid_C2", host_rvalid, 0);
    check("rd_rdata_hold", host_rdata, RD_EN ? 16'hBEEF : 16'h0000);

    // Overrun: retrigger on the tenth fetch cycle.
    line = 1'b1; sy = 16'sd3;
    #1;
    check("ovr_flag_pre", fetch_overrun, 0);
    for (int k = 0; k < 9; k++) begin
      tick();
      line = 1'b0;
      #1;
      check($sformatf("ovr_addr_k%0d", k), mem_addr, 160 + k);
    end
    tick();
    line = 1'b1; sy = 16'sd4;
    #1;
    check("ovr_addr_k9", mem_addr, 169);
    check("ovr_flag_k9", fetch_overrun, 0);
    run_fetch(200, 1'b0, 1'b0);
    check("ovr_flag_set", fetch_overrun, 1);
    tick(); tick();
    check("ovr_flag_sticky", fetch_overrun, 1);

    // Reset mid-fetch, then silence until the next trigger.
    line = 1'b1; sy = 16'sd5;
    for (int k = 0; k < 5; k++) begin
      tick();
      line = 1'b0;
    end
    #1;
    check("pre_rst_busy", fetch_busy, 1);
    #1 rst_pix_n = 1'b0;
    #1;
    check_reset_outputs();
    tick(); tick();
    #2 rst_pix_n = 1'b1;
    saw_we = 1'b0;
    for (int k = 0; k < 45; k++) begin
      tick();
      if (lb_we !== 1'b0 || fetch_busy !== 1'b0) saw_we = 1'b1;
    end
    check("post_rst_quiet", saw_we, 0);
    frame = 1'b1; line = 1'b1; sy = -16'sd1;
    #1;
    run_fetch(0, 1'b1, 1'b0);
    check("post_rst_overrun", fetch_overrun, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
